// File: rtl/rram_ctrl_pkg.sv
// Shared encodings for the RRAM access sequencer: op codes, FSM states,
// register offsets and reset values.
package rram_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_READ     = 2'd0,
    OP_SET      = 2'd1,
    OP_RESET    = 2'd2,
    OP_ROW_READ = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [1:0]  REG_CTRL   = 2'd0;
  localparam logic [1:0]  REG_TIMING = 2'd1;
  localparam logic [1:0]  REG_STATUS = 2'd2;
  localparam logic [1:0]  REG_RDATA  = 2'd3;

  localparam logic [23:0] TIMING_RST = 24'h02_0A_02;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  function automatic logic is_read_op(input op_e op);
    return (op == OP_READ) || (op == OP_ROW_READ);
  endfunction

endpackage

// File: rtl/rram_access_ctrl_phase_timer.sv
// Down-counter reloaded at every phase entry; a load value of 0 behaves as 1.
module rram_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down and park at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val == '0) ? CNT_W'(1) : load_val;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/rram_access_ctrl.sv
// Wishbone-programmable WL/BL pulse sequencer for the 16x16 1T1R RRAM array,
// with synchronised source-line capture for read operations.
module rram_access_ctrl
  import rram_ctrl_pkg::*;
#(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int CNT_W  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [N_ROWS-1:0] wl,
  output logic [N_COLS-1:0] bl,
  input  logic [N_COLS-1:0] sl,
  output logic [1:0]        op_mode,
  output logic              busy,
  output logic              irq
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [3:0]        row_q, row_d, col_q, col_d;
  logic [23:0]       shadow_q, shadow_d, timing_q, timing_d;
  logic [30:0]       ctrl_q, ctrl_d;
  logic              done_q, done_d, err_q, err_d;
  logic [16:0]       rdata_q, rdata_d;
  logic [N_COLS-1:0] sync1_q, sync2_q;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [N_ROWS-1:0] wl_q, wl_d;
  logic [N_COLS-1:0] bl_q, bl_d;
  logic              busy_q, busy_d;
  logic [1:0]        op_mode_q, op_mode_d;

  logic              req_s, wr_s, ctrl_wr_s, start_s, accept_s, set_done_s;
  logic [1:0]        adr_s;
  logic              load_s, expired_s;
  logic [CNT_W-1:0]  load_val_s;
  logic              unused_s;

  assign req_s     = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_s      = req_s & wbs_we_i;
  assign adr_s     = wbs_adr_i[3:2];
  assign ctrl_wr_s = wr_s & (adr_s == REG_CTRL) & wbs_sel_i[0];
  assign start_s   = ctrl_wr_s & wbs_dat_i[31];
  assign accept_s  = start_s & (state_q == ST_IDLE);
  assign unused_s  = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3]};

  // Sequencer next state, command latch and read-data capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    row_d      = row_q;
    col_d      = col_q;
    shadow_d   = shadow_q;
    rdata_d    = rdata_q;
    set_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d  = ST_SETUP;
          op_d     = op_e'(wbs_dat_i[1:0]);
          row_d    = wbs_dat_i[7:4];
          col_d    = wbs_dat_i[11:8];
          shadow_d = timing_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP:  state_d = expired_s ? ST_PULSE : ST_SETUP;
      ST_PULSE: begin
        if (expired_s) begin
          state_d = is_read_op(op_q) ? ST_SAMPLE : ST_HOLD;
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_SAMPLE: begin
        if (expired_s) begin
          state_d = ST_HOLD;
          rdata_d = {sync2_q[col_q], sync2_q};
        end else begin
          state_d = ST_SAMPLE;
        end
      end
      ST_HOLD: begin
        if (expired_s) begin
          state_d    = ST_DONE;
          set_done_s = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Phase timer reload on every state change, and registered pin drives
  // computed from the upcoming state so wl/bl change cleanly on the edge.
  always_comb begin
    load_s     = (state_d != state_q);
    load_val_s = CNT_W'(1);
    wl_d       = '0;
    bl_d       = '0;
    case (state_d)
      ST_SETUP:  load_val_s = CNT_W'(shadow_d[7:0]);
      ST_PULSE:  load_val_s = CNT_W'(shadow_d[15:8]);
      ST_SAMPLE: load_val_s = CNT_W'(2);
      ST_HOLD:   load_val_s = CNT_W'(shadow_d[23:16]);
      default:   load_val_s = CNT_W'(1);
    endcase
    case (state_d)
      ST_SETUP, ST_HOLD: wl_d = {{(N_ROWS-1){1'b0}}, 1'b1} << row_d;
      ST_PULSE, ST_SAMPLE: begin
        wl_d = {{(N_ROWS-1){1'b0}}, 1'b1} << row_d;
        bl_d = (op_d == OP_ROW_READ) ? {N_COLS{1'b1}}
                                     : ({{(N_COLS-1){1'b0}}, 1'b1} << col_d);
      end
      default: begin
        wl_d = '0;
        bl_d = '0;
      end
    endcase
    busy_d    = (state_d != ST_IDLE);
    op_mode_d = busy_d ? 2'(op_d) : 2'd0;
  end

  // Wishbone register file: writes, W1C status and read-data mux.
  always_comb begin
    ack_d    = req_s;
    dat_d    = 32'd0;
    ctrl_d   = ctrl_wr_s ? wbs_dat_i[30:0] : ctrl_q;
    timing_d = timing_q;
    done_d   = done_q;
    err_d    = err_q;
    if (wr_s && (adr_s == REG_TIMING)) begin
      for (int b = 0; b < 3; b++) begin
        timing_d[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : timing_q[8*b +: 8];
      end
    end else begin
      timing_d = timing_q;
    end
    // A status set in the same cycle as its W1C clear takes priority.
    if (wr_s && (adr_s == REG_STATUS) && wbs_sel_i[0]) begin
      done_d = wbs_dat_i[STAT_DONE] ? 1'b0 : done_q;
      err_d  = wbs_dat_i[STAT_ERR]  ? 1'b0 : err_q;
    end else begin
      done_d = done_q;
      err_d  = err_q;
    end
    done_d = set_done_s ? 1'b1 : done_d;
    err_d  = (start_s && !accept_s) ? 1'b1 : err_d;
    if (req_s && !wbs_we_i) begin
      case (adr_s)
        REG_CTRL:   dat_d = {1'b0, ctrl_q};
        REG_TIMING: dat_d = {8'd0, timing_q};
        REG_STATUS: dat_d = {29'd0, err_q, done_q, (state_q != ST_IDLE)};
        REG_RDATA:  dat_d = {15'd0, rdata_q};
        default:    dat_d = 32'd0;
      endcase
    end else begin
      dat_d = 32'd0;
    end
  end

  // All state, register-file and output flops.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_READ;
      row_q     <= 4'd0;
      col_q     <= 4'd0;
      shadow_q  <= TIMING_RST;
      timing_q  <= TIMING_RST;
      ctrl_q    <= 31'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 17'd0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
      wl_q      <= '0;
      bl_q      <= '0;
      busy_q    <= 1'b0;
      op_mode_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      row_q     <= row_d;
      col_q     <= col_d;
      shadow_q  <= shadow_d;
      timing_q  <= timing_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      sync1_q   <= sl;
      sync2_q   <= sync1_q;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      wl_q      <= wl_d;
      bl_q      <= bl_d;
      busy_q    <= busy_d;
      op_mode_q <= op_mode_d;
    end
  end

  rram_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (load_s),
    .load_val (load_val_s),
    .expired  (expired_s)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign wl        = wl_q;
  assign bl        = bl_q;
  assign busy      = busy_q;
  assign op_mode   = op_mode_q;
  assign irq       = done_q;

endmodule

// File: doc/rram_access_ctrl.md
Name: rram_access_ctrl

Overview:
Wishbone-programmable sequencer for the 16x16 1T1R RRAM array wrapper. It converts single register commands into timed word-line/bit-line pulse sequences for READ, SET, RESET and ROW-READ. For reads it samples the source-line outputs through a synchroniser and reports completion through a status flag and irq. It sits in the user project between the Wishbone slave port and the array wrapper's WL/BL/SL pins.

Parameters:
N_ROWS, 16, word lines driven (one-hot)
N_COLS, 16, bit lines driven and source lines sampled
CNT_W, 8, width of each phase-duration field

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  asynchronous active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe; block already address-selected by parent
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  address; only [3:2] decoded
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
wl  out  N_ROWS  word-line drive, one-hot or zero
bl  out  N_COLS  bit-line drive
sl  in  N_COLS  source-line sense from array (asynchronous to clock)
op_mode  out  2  current op for analog polarity driver; 0 when idle
busy  out  1  sequence in progress
irq  out  1  equals STATUS.done

Behaviour:
- Reset (async, immediate): wl=0, bl=0, op_mode=0, busy=0, irq=0, wbs_ack_o=0, wbs_dat_o=0. FSM=IDLE. TIMING=0x00_02_0A_02. STATUS=0. RDATA=0. Synchroniser flops=0.
- Wishbone: when cyc&stb&!ack, assert ack for exactly 1 cycle on the next clock; register effects are applied on that same edge; wbs_dat_o is valid with ack. Byte selects honoured on TIMING only; CTRL and STATUS writes need sel[0].
- Register map:
  0x0 CTRL (W): [1:0] op (0 READ, 1 SET, 2 RESET, 3 ROW-READ), [7:4] row, [11:8] col, [31] start. Reads return last written value with [31]=0.
  0x4 TIMING (R/W): [7:0] setup, [15:8] pulse, [23:16] hold; a field value of 0 means 1 cycle.
  0x8 STATUS: [0] busy (RO), [1] done (W1C), [2] err (W1C).
  0xC RDATA (RO): [15:0] sampled sl word, [16] = sampled sl[col].
- Start: a CTRL write with [31]=1 while IDLE latches op/row/col plus a TIMING shadow copy. SETUP is entered on the next cycle. A start while busy is ignored and sets err. TIMING writes during busy do not affect the running op.
- FSM: IDLE -> SETUP -> PULSE -> [SAMPLE, read ops only] -> HOLD -> DONE -> IDLE.
  - SETUP: wl[row]=1, bl=0.
  - PULSE: wl[row]=1; bl = one-hot col (READ/SET/RESET) or all ones (ROW-READ).
  - SAMPLE: lasts 2 cycles with the PULSE drive held, covering the 2-flop sl synchroniser. On its last cycle the synchronised sl is captured into RDATA.
  - HOLD: wl[row]=1, bl=0.
  - DONE: 1 cycle, all drives 0; sets STATUS.done.
  - busy=1 and op_mode=op in every state except IDLE.
- Phase counters count down from the shadow value (0 treated as 1).
- Default latencies (busy high): READ/ROW-READ 2+10+2+2+1=17 cycles; SET/RESET 15 cycles.
- Same-cycle done set and W1C clear: set wins.
- wl and bl are registered outputs, never multi-hot on wl, glitch-free.

Decomposition:
- Package rram_ctrl_pkg: op encodings, FSM state enum, register offsets, TIMING reset constant, STATUS bit indices.
- Sub-module rram_phase_timer (load/count-down/expire, CNT_W wide), instantiated once and reloaded per phase.
- Wishbone register file and FSM live in the top module.

Test Plan:
- Reset defaults: after reset, read TIMING -> 0x00020A02; STATUS -> 0; wl=bl=0.
- SET row 3 col 5, default timing: wl=0x0008 for 14 cycles; bl=0x0020 for exactly 10 of them; op_mode=1; busy for 15 cycles; STATUS=0x2; irq=1.
- READ row 7 col 2 with sl tied to 0x0004: RDATA=0x00010004; busy 17 cycles. Then W1C STATUS 0x2 -> irq=0.
- ROW-READ row 15 with sl=0xA5A5: bl=0xFFFF during PULSE; RDATA[15:0]=0xA5A5.
- Start issued mid-sequence: running op is unaffected, STATUS.err=1. A TIMING write during busy takes effect only on the next op (setup=0 gives a 1-cycle SETUP).
- Reset asserted mid-PULSE: wl and bl go to 0 without waiting for a clock edge; FSM returns to IDLE; done stays 0.
